// File: rtl/mem_param_clr_if.sv
// Access bus for mem_param_clr: request side, status side and read return.
// master drives requests; slave is the memory.
interface mem_param_clr_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req;
  logic              r_w;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              clr;
  logic              ready;
  logic              busy;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;

  modport master (
    output req,
    output r_w,
    output addr,
    output data_in,
    output clr,
    input  ready,
    input  busy,
    input  data_out,
    input  rd_valid
  );

  modport slave (
    input  req,
    input  r_w,
    input  addr,
    input  data_in,
    input  clr,
    output ready,
    output busy,
    output data_out,
    output rd_valid
  );
endinterface

// File: rtl/mem_param_clr.sv
// Single-port word memory with a self-clearing engine.
// Every reset and every clr request sweeps CLR_VAL over the whole array.
module mem_param_clr #(
  parameter int              DATA_W  = 8,
  parameter int              ADDR_W  = 8,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  mem_param_clr_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              ready;
  logic              busy;
  logic              rd_valid;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] mem [DEPTH];

  logic acc;
  logic acc_rd;
  logic acc_wr;
  logic last;

  assign acc    = bus.req && ready;
  assign acc_rd = acc && bus.r_w;
  assign acc_wr = acc && !bus.r_w;
  assign last   = &clr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
      busy    <= 1'b1;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (last) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (bus.clr) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Array has no reset; the sweep is its only initialisation.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_ptr] <= CLR_VAL;
    end else if (acc_wr) begin
      mem[bus.addr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      data_out <= '0;
    end else begin
      rd_valid <= acc_rd;
      if (acc_rd) begin
        data_out <= mem[bus.addr];
      end
    end
  end

  assign bus.ready    = ready;
  assign bus.busy     = busy;
  assign bus.rd_valid = rd_valid;
  assign bus.data_out = data_out;
endmodule
